dm_access_unit: RTL and testbench

- Initiator-side load/store unit that drives the word-addressed data memory (DM) on behalf of a multicycle core.
- Accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake.
- Translates each request to a word index and performs read-modify-write for sub-word stores; memory read data is combinational.
- Extracts and sign/zero-extends load data, and flags out-of-range accesses with ERR_CODE.

---
 rtl/dm_access_unit_if.sv | 36 +++
 rtl/dm_access_unit.sv | 160 ++++++++++++++++
 tb/tb_dm_access_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_unit_if.sv
// ============================================================================
// dm_access_unit_if : request/response and data-memory signal bundle for dm_access_unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface dm_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  // Unit side: takes requests, drives the DM.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
  );

  // Environment side: core issuing requests plus the DM itself.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
  );
endinterface

`default_nettype wire

// File: rtl/dm_access_unit.sv
// ============================================================================
// dm_access_unit : byte/half/word load-store unit for a word-addressed data memory
// Optional: MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
// Rev 1.0
// ============================================================================
`default_nettype none

module dm_access_unit #(
  parameter int          DEPTH    = 100,
  parameter logic [31:0] ERR_CODE = 32'hDEAD
) (
  input  wire logic        clk,
  input  wire logic        rst,
  dm_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wd_q;

  logic [29:0] idx_d;
  logic        acc_err_d;
  logic [1:0]  off_d;
  logic [31:0] load_d;
  logic [31:0] merge_d;
  logic [7:0]  rd_byte_d;
  logic [15:0] rd_half_d;
  logic [4:0]  shamt_d;

  always_comb begin
    idx_d     = bus.req_addr[31:2];
    acc_err_d = ({2'b00, idx_d} >= 32'(DEPTH)) || (bus.req_size == 2'b11);
`ifdef MISALIGN_TRAP_EN
    if ((bus.req_size == 2'b01 && bus.req_addr[0]) ||
        (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00))
      acc_err_d = 1'b1;
`endif
    // Without trapping, misaligned low bits are simply dropped.
    case (bus.req_size)
      2'b00:   off_d = bus.req_addr[1:0];
      2'b01:   off_d = {bus.req_addr[1], 1'b0};
      default: off_d = 2'b00;
    endcase
  end

  always_comb begin
    shamt_d   = {off_q, 3'b000};
    rd_byte_d = 8'(bus.mem_rd >> shamt_d);
    rd_half_d = 16'(bus.mem_rd >> shamt_d);
    case (size_q)
      2'b00:   load_d = signed_q ? {{24{rd_byte_d[7]}}, rd_byte_d} : {24'b0, rd_byte_d};
      2'b01:   load_d = signed_q ? {{16{rd_half_d[15]}}, rd_half_d} : {16'b0, rd_half_d};
      default: load_d = bus.mem_rd;
    endcase
    if (size_q == 2'b00)
      merge_d = (bus.mem_rd & ~(32'h0000_00FF << shamt_d)) | ({24'b0, wdata_q[7:0]} << shamt_d);
    else
      merge_d = (bus.mem_rd & ~(32'h0000_FFFF << shamt_d)) | ({16'b0, wdata_q} << shamt_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 16'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wd_q     <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            write_q     <= bus.req_write;
            size_q      <= bus.req_size;
            signed_q    <= bus.req_signed;
            off_q       <= off_d;
            wdata_q     <= bus.req_wdata[15:0];
            req_ready_q <= 1'b0;
            if (acc_err_d) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= ERR_CODE;
              state_q      <= S_RESP;
            end else begin
              mem_addr_q <= {2'b00, idx_d};
              if (bus.req_write && bus.req_size == 2'b10) begin
                mem_we_q <= 1'b1;
                mem_wd_q <= bus.req_wdata;
                state_q  <= S_WR;
              end else begin
                state_q  <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (write_q) begin
            mem_we_q <= 1'b1;
            mem_wd_q <= merge_d;
            state_q  <= S_WR;
          end else begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_d;
            state_q      <= S_RESP;
          end
        end
        S_WR: begin
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wd     = mem_wd_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_access_unit.sv
// ============================================================================
// tb_dm_access_unit : directed + random checks of dm_access_unit against a memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dm_access_unit;
  localparam int          DEPTH    = 100;
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] ERR_CODE = 32'hDEAD;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic dm_init;
  always #5 clk = ~clk;

  dm_access_unit_if bus ();

  dm_access_unit #(.DEPTH(DEPTH), .ERR_CODE(ERR_CODE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] dm    [DEPTH];
  logic [31:0] model [DEPTH];

  function automatic logic [31:0] seed_word(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign bus.mem_rd = (bus.mem_addr < 32'(DEPTH)) ? dm[bus.mem_addr[AW-1:0]] : 32'h0;

  always @(posedge clk) begin
    if (dm_init) begin
      for (int i = 0; i < DEPTH; i++) dm[i] <= seed_word(i);
    end else if (bus.mem_we && bus.mem_addr < 32'(DEPTH)) begin
      dm[bus.mem_addr[AW-1:0]] <= bus.mem_wd;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] size, bit sgn, logic [31:0] addr);
    logic [31:0] v;
    int sh;
    case (size)
      2'b00: begin
        sh = int'(addr[1:0]) * 8;
        v  = (w >> sh) & 32'hFF;
        if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        sh = int'(addr[1]) * 16;
        v  = (w >> sh) & 32'hFFFF;
        if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] w, logic [1:0] size, logic [31:0] addr, logic [31:0] d);
    int sh;
    logic [31:0] m;
    case (size)
      2'b00:   begin sh = int'(addr[1:0]) * 8; m = 32'hFF;   end
      2'b01:   begin sh = int'(addr[1]) * 16;  m = 32'hFFFF; end
      default: return d;
    endcase
    return (w & ~(m << sh)) | ((d & m) << sh);
  endfunction

  task automatic do_req(input bit wr, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag, output logic [31:0] rd_out);
    logic [31:0] idx, exp_rd, exp_wd, we_addr, we_wd, got_rd, got_err;
    bit          err, mis;
    int          lat, got_lat, we_cnt, k;
    idx = addr >> 2;
    mis = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    err = (idx >= 32'(DEPTH)) || (size == 2'b11) || (TRAP && mis);
    lat = err ? 1 : (!wr ? 2 : (size == 2'b10 ? 2 : 3));
    exp_rd = 32'h0;
    exp_wd = 32'h0;
    if (err) exp_rd = ERR_CODE;
    else if (!wr) exp_rd = ref_load(model[idx[AW-1:0]], size, sgn, addr);
    else exp_wd = ref_store(model[idx[AW-1:0]], size, addr, wdata);

    @(negedge clk);
    k = 0;
    while (!bus.req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;

    got_lat = 0; we_cnt = 0; we_addr = 0; we_wd = 0; got_rd = 0; got_err = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        we_cnt++;
        we_addr = bus.mem_addr;
        we_wd   = bus.mem_wd;
      end
      if (bus.resp_valid) begin
        got_lat = n;
        got_rd  = bus.resp_rdata;
        got_err = 32'(bus.resp_err);
        break;
      end
    end
    check({tag, "/latency"}, 32'(got_lat), 32'(lat));
    check({tag, "/err"}, got_err, 32'(err));
    check({tag, "/rdata"}, got_rd, exp_rd);
    check({tag, "/we_cycles"}, 32'(we_cnt), (!err && wr) ? 32'd1 : 32'd0);
    if (!err && wr) begin
      check({tag, "/we_addr"}, we_addr, idx);
      check({tag, "/we_data"}, we_wd, exp_wd);
      model[idx[AW-1:0]] = exp_wd;
    end
    @(negedge clk);
    check({tag, "/pulse"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "/ready_after"}, 32'(bus.req_ready), 32'd1);
    check({tag, "/hold"}, bus.resp_rdata, exp_rd);
    rd_out = got_rd;
  endtask

  logic [31:0] r;

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = seed_word(i);
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    dm_init = 1'b1;
    rst = 1'b1;
    #1;
    check("rst/ready", 32'(bus.req_ready), 32'd1);
    check("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst/rdata", bus.resp_rdata, 32'h0);
    check("rst/err", 32'(bus.resp_err), 32'd0);
    check("rst/we", 32'(bus.mem_we), 32'd0);
    check("rst/addr", bus.mem_addr, 32'h0);
    check("rst/wd", bus.mem_wd, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    dm_init = 1'b0;
    rst = 1'b0;

    do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h8081_82F3, "sw14", r);
    do_req(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, "lb14", r);
    check("tp/lb14", r, 32'hFFFF_FFF3);
    do_req(1'b0, 2'b00, 1'b0, 32'h15, 32'h0, "lbu15", r);
    check("tp/lbu15", r, 32'h0000_0082);
    do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, "lh16", r);
    check("tp/lh16", r, 32'hFFFF_8081);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, "lw14", r);
    check("tp/lw14", r, 32'h8081_82F3);
    do_req(1'b0, 2'b01, 1'b1, 32'h15, 32'h0, "lh15", r);
    check("tp/lh15", r, TRAP ? 32'h0000_DEAD : 32'hFFFF_82F3);
    do_req(1'b1, 2'b00, 1'b0, 32'h17, 32'h0000_00AA, "sb17", r);
    check("tp/sb17_mem", dm[5], 32'hAA81_82F3);
    do_req(1'b0, 2'b10, 1'b0, 32'h190, 32'h0, "lw190", r);
    check("tp/lw190", r, 32'h0000_DEAD);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, "rsvd", r);
    do_req(1'b0, 2'b10, 1'b0, 32'h18C, 32'h0, "lw_last", r);

    // Abort a halfword store while its write is being presented.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
    bus.req_signed = 1'b0; bus.req_addr = 32'h14; bus.req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort/we_before", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("abort/we_drop", 32'(bus.mem_we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort/no_resp", 32'(bus.resp_valid), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("abort/ready", 32'(bus.req_ready), 32'd1);
    check("abort/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort/dm5", dm[5], model[5]);

    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 15));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, "rand", r);
    end

    for (int i = 0; i < DEPTH; i++) check("final/dm", dm[i], model[i]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=%0d", n_checks, 0);
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
